// File: rtl/slot_pkg.sv
// -----------------------------------------------------------------------------
// slot_pkg
// Shared definitions for the Slot sequencer input chain: the debounce channel
// state encoding (also decoded by the bench) and the default timing constants.
// -----------------------------------------------------------------------------
package slot_pkg;

    // Bit 1 of the encoding is the debounced level; bit 0 marks a pending change.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } chan_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_SYNC_STAGES     = 2;

    // Settled state for a given debounced level.
    function automatic chan_state_e stable_state(input logic level);
        return level ? STABLE_HI : STABLE_LO;
    endfunction

    // Pending state while counting away from a given debounced level.
    function automatic chan_state_e pend_state(input logic level);
        return level ? PEND_LO : PEND_HI;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// Single-bit synchronizer followed by a counter-based debouncer. The debounced
// level changes on the DEBOUNCE_CYCLES-th consecutive sample that disagrees
// with it; any agreeing sample restarts the count.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_x          : polarity-corrected asynchronous input
//   o_level      : debounced level
//   o_rise/o_fall: one-cycle pulse when o_level goes 0->1 / 1->0
//   o_busy       : a transition is pending (counter non-zero)
// -----------------------------------------------------------------------------
module debounce_channel
    import slot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_x,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    chan_state_e            r_state;
    chan_state_e            w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   w_s;
    logic                   w_db;

    assign w_s  = r_sync[SYNC_STAGES-1];
    assign w_db = r_state[1];

    // State register: synchronizer chain, channel state, counter, pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_x};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Next-state: count disagreeing samples, flip the level at terminal count.
    always_comb begin
        w_state_nxt = stable_state(w_db);
        w_cnt_nxt   = '0;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (w_s != w_db) begin
            if (r_cnt == CNT_MAX) begin
                w_state_nxt = stable_state(w_s);
                w_rise_nxt  = w_s;
                w_fall_nxt  = ~w_s;
            end else begin
                w_state_nxt = pend_state(w_db);
                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs: all taken straight from registers.
    always_comb begin
        o_level = w_db;
        o_rise  = r_rise;
        o_fall  = r_fall;
        o_busy  = (r_cnt != '0);
    end

endmodule

// File: rtl/slot_input_conditioner.sv
// -----------------------------------------------------------------------------
// slot_input_conditioner
// Conditions raw board inputs for the Slot sequencer: polarity correction,
// synchronization and debouncing for N_IN condition channels plus a START
// button whose debounced rising edge launches the first slot.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_raw_in       : raw condition inputs (bit 0 -> IN1)
//   i_raw_start    : raw start button
//   o_in_level     : debounced condition levels
//   o_in_rise/fall : one-cycle pulses on debounced edges
//   o_start_pulse  : one-cycle pulse on debounced START press
//   o_start_level  : debounced START level
//   o_busy         : any channel has a pending transition
// -----------------------------------------------------------------------------
module slot_input_conditioner
    import slot_pkg::*;
#(
    parameter int unsigned      N_IN             = 3,
    parameter int unsigned      DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned      SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter logic [N_IN-1:0]  ACTIVE_LOW_MASK  = '0,
    parameter logic             START_ACTIVE_LOW = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N_IN-1:0] i_raw_in,
    input  logic            i_raw_start,
    output logic [N_IN-1:0] o_in_level,
    output logic [N_IN-1:0] o_in_rise,
    output logic [N_IN-1:0] o_in_fall,
    output logic            o_start_pulse,
    output logic            o_start_level,
    output logic            o_busy
);

    logic [N_IN-1:0] w_x;
    logic [N_IN-1:0] w_busy;
    logic            w_start_x;
    logic            w_start_busy;
    logic            w_start_fall_unused;

    // Polarity correction ahead of the first synchronizer flop.
    assign w_x       = i_raw_in ^ ACTIVE_LOW_MASK;
    assign w_start_x = i_raw_start ^ START_ACTIVE_LOW;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst   (i_reset),
            .i_x     (w_x[gi]),
            .o_level (o_in_level[gi]),
            .o_rise  (o_in_rise[gi]),
            .o_fall  (o_in_fall[gi]),
            .o_busy  (w_busy[gi])
        );
    end

    // START is an ordinary channel; only its rise is exported as a pulse.
    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_start (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_x     (w_start_x),
        .o_level (o_start_level),
        .o_rise  (o_start_pulse),
        .o_fall  (w_start_fall_unused),
        .o_busy  (w_start_busy)
    );

    assign o_busy = (|w_busy) | w_start_busy;

endmodule

// File: tb/tb_slot_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_slot_input_conditioner
// Directed bench for slot_input_conditioner with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2, channel 0 active-low. A clean step shows up on the debounced
// outputs 6 edges after it is applied, with BUSY high after edges 3..5.
// -----------------------------------------------------------------------------
module tb_slot_input_conditioner;
    import slot_pkg::*;

    localparam int unsigned N_IN = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_IN-1:0] raw_in;
    logic            raw_start;
    logic [N_IN-1:0] in_level;
    logic [N_IN-1:0] in_rise;
    logic [N_IN-1:0] in_fall;
    logic            start_pulse;
    logic            start_level;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    slot_input_conditioner #(
        .N_IN             (N_IN),
        .DEBOUNCE_CYCLES  (4),
        .SYNC_STAGES      (2),
        .ACTIVE_LOW_MASK  (3'b001),
        .START_ACTIVE_LOW (1'b0)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_raw_in      (raw_in),
        .i_raw_start   (raw_start),
        .o_in_level    (in_level),
        .o_in_rise     (in_rise),
        .o_in_fall     (in_fall),
        .o_start_pulse (start_pulse),
        .o_start_level (start_level),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Six edges after a clean step: pulses only on edge 6, BUSY on edges 3..5.
    task automatic run_step(input string tag, input logic [2:0] exp_rise,
                            input logic [2:0] exp_fall, input logic exp_start);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("%s_rise_e%0d", tag, k), 32'(in_rise), 32'((k == 6) ? exp_rise : 3'b000));
            chk($sformatf("%s_fall_e%0d", tag, k), 32'(in_fall), 32'((k == 6) ? exp_fall : 3'b000));
            chk($sformatf("%s_spulse_e%0d", tag, k), 32'(start_pulse), 32'((k == 6) ? exp_start : 1'b0));
            chk($sformatf("%s_busy_e%0d", tag, k), 32'(busy), 32'((k >= 3 && k <= 5) ? 1'b1 : 1'b0));
        end
    endtask

    function automatic logic start_sched(input int t);
        return ((t >= 1 && t <= 20) || (t >= 31 && t <= 50)) ? 1'b1 : 1'b0;
    endfunction

    initial begin
        int   rise_cnt;
        int   pulse_cnt;
        logic lvl_exp;
        logic lvl_prev;

        // Reset with every raw input low; channel 0 reads as active (inverted).
        rst       = 1'b1;
        raw_in    = 3'b000;
        raw_start = 1'b0;
        tick();
        tick();
        chk("rst_level",  32'(in_level), 32'd0);
        chk("rst_rise",   32'(in_rise), 32'd0);
        chk("rst_fall",   32'(in_fall), 32'd0);
        chk("rst_spulse", 32'(start_pulse), 32'd0);
        chk("rst_slevel", 32'(start_level), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);

        // Polarity: active-low channel 0 rises a full debounce after release.
        rst = 1'b0;
        run_step("pol", 3'b001, 3'b000, 1'b0);
        chk("pol_level", 32'(in_level), 32'b001);
        tick();
        chk("pol_rise_clear", 32'(in_rise), 32'd0);

        // Clean press/release on channel 0 (active-low raw).
        raw_in[0] = 1'b1;
        run_step("ch0_off", 3'b000, 3'b001, 1'b0);
        chk("ch0_off_level", 32'(in_level), 32'b000);
        raw_in[0] = 1'b0;
        run_step("ch0_on", 3'b001, 3'b000, 1'b0);
        chk("ch0_on_level", 32'(in_level), 32'b001);

        // Bounce on channel 1: 1,0,1,0 one cycle each, then hold 1.
        rise_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            raw_in[1] = (b % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            chk($sformatf("bnc_rise_b%0d", b), 32'(in_rise[1]), 32'd0);
            chk($sformatf("bnc_fall_b%0d", b), 32'(in_fall[1]), 32'd0);
            rise_cnt += int'(in_rise[1]);
        end
        raw_in[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("bnc_hold_rise_e%0d", k), 32'(in_rise[1]), 32'((k == 6) ? 1 : 0));
            chk($sformatf("bnc_hold_level_e%0d", k), 32'(in_level[1]), 32'((k == 6) ? 1 : 0));
            rise_cnt += int'(in_rise[1]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            rise_cnt += int'(in_rise[1]);
        end
        chk("bnc_rise_count", 32'(rise_cnt), 32'd1);

        // Release on channel 2 after it has settled high.
        raw_in[2] = 1'b1;
        run_step("ch2_set", 3'b100, 3'b000, 1'b0);
        raw_in[2] = 1'b0;
        run_step("ch2_rel", 3'b000, 3'b100, 1'b0);
        chk("ch2_rel_level", 32'(in_level), 32'b011);
        tick();
        chk("ch2_fall_clear", 32'(in_fall), 32'd0);

        // START one-shot: high 20, low 10, high 20; level lags raw by 5 steps.
        pulse_cnt = 0;
        lvl_prev  = 1'b0;
        for (int t = 1; t <= 50; t++) begin
            raw_start = start_sched(t);
            tick();
            lvl_exp = start_sched(t - 5);
            chk($sformatf("start_level_t%0d", t), 32'(start_level), 32'(lvl_exp));
            chk($sformatf("start_pulse_t%0d", t), 32'(start_pulse), 32'(lvl_exp & ~lvl_prev));
            pulse_cnt += int'(start_pulse);
            lvl_prev = lvl_exp;
            if (t == 3)  chk("start_state_t3",  32'(dut.u_start.r_state), 32'(PEND_HI));
            if (t == 23) chk("start_state_t23", 32'(dut.u_start.r_state), 32'(PEND_LO));
        end
        chk("start_pulse_count", 32'(pulse_cnt), 32'd2);
        chk("start_state_end", 32'(dut.u_start.r_state), 32'(STABLE_HI));

        // Reset asserted asynchronously while channel 2 is mid-count.
        raw_in[2] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level",  32'(in_level), 32'd0);
        chk("arst_rise",   32'(in_rise), 32'd0);
        chk("arst_fall",   32'(in_fall), 32'd0);
        chk("arst_slevel", 32'(start_level), 32'd0);
        chk("arst_spulse", 32'(start_pulse), 32'd0);
        chk("arst_busy",   32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        // Every channel is already active; all rise together after a full debounce.
        run_step("rel", 3'b111, 3'b000, 1'b1);
        chk("rel_level",  32'(in_level), 32'b111);
        chk("rel_slevel", 32'(start_level), 32'd1);

        // Simultaneity: all three channels fall, then rise, on the same edge.
        raw_in = 3'b001;
        run_step("sim_fall", 3'b000, 3'b111, 1'b0);
        raw_in = 3'b110;
        run_step("sim_rise", 3'b111, 3'b000, 1'b0);
        chk("sim_level", 32'(in_level), 32'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slot_input_conditioner.md
Name: slot_input_conditioner

Overview:
- Upstream stage of the Slot sequencer chain; it conditions raw board inputs (DIP switches, push-buttons) before they reach a Slot's IN1..IN3 condition inputs.
- Per channel it performs polarity correction, a multi-flop synchronizer, and a counter-based debouncer.
- It produces clean levels, one-cycle rise/fall pulses, and a debounced one-shot START pulse for launching the first (INICIO) slot.

Parameters:
N_IN, 3, number of condition channels (maps to IN1..IN3)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced level changes (1 ms at 50 MHz); minimum 2
SYNC_STAGES, 2, synchronizer flop depth; minimum 2
ACTIVE_LOW_MASK, 3'b000, per-channel mask; bit set = raw input inverted before synchronization
START_ACTIVE_LOW, 1'b0, inverts RAW_START before synchronization

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
RAW_IN  input  N_IN  asynchronous raw condition inputs (bit0 -> IN1)
RAW_START  input  1  asynchronous raw start button
IN_LEVEL  output  N_IN  debounced levels, wired to Slot IN1..IN3
IN_RISE  output  N_IN  one-cycle pulse on debounced 0->1
IN_FALL  output  N_IN  one-cycle pulse on debounced 1->0
START_PULSE  output  1  one-cycle pulse on debounced START 0->1
START_LEVEL  output  1  debounced START level
BUSY  output  1  high while any channel's counter is non-zero (a transition is pending)

Behaviour:
- Reset:
  - One clock (CLK) and one reset (RESET).
  - RESET is asynchronous and active-high. All flops clear immediately on assertion.
  - Reset values: IN_LEVEL=0, IN_RISE=0, IN_FALL=0, START_PULSE=0, START_LEVEL=0, BUSY=0.
  - Synchronizer flops and counters also clear to 0.
  - Release is synchronous to CLK at the next edge.
- Polarity: x = raw XOR mask bit, applied before the first synchronizer flop.
- Synchronizer: chain of SYNC_STAGES flops; s = last stage.
- Debounce, per channel (the START channel is identical):
  - Registers: db (debounced level) and cnt, width $clog2(DEBOUNCE_CYCLES).
  - If s == db: cnt <= 0.
  - If s != db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If s != db and cnt == DEBOUNCE_CYCLES-1: db <= s, cnt <= 0, and the rise or fall pulse register is set for exactly that one cycle.
  - Net effect: db changes on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  - A single matching cycle (glitch/bounce) restarts the count from 0.
- Pulses:
  - IN_RISE and IN_FALL are registered and asserted in the same cycle db updates.
  - They are never both high on one channel, and are deasserted the following cycle.
- Latency: raw step to IN_LEVEL change = SYNC_STAGES + DEBOUNCE_CYCLES clock edges, given a clean input.
- Channel FSM view: STABLE_LO, PEND_HI (cnt counting), STABLE_HI, PEND_LO.
  - PEND_* falls back to STABLE_* on any matching sample.
  - PEND_* advances to the opposite STABLE_* at terminal count.
- START:
  - START_PULSE fires only on the START channel's rise.
  - Holding the button produces no further pulses.
  - A new pulse requires a debounced release followed by a debounced press.
- BUSY: combinational OR of (cnt != 0) across all N_IN+1 channels.
- Channels are fully independent; simultaneous transitions on several channels give simultaneous pulses.
- Reset mid-count: the count is lost and the channel returns to STABLE_LO. No pulse is emitted on reset release, even if the raw input is already active; the rise pulse appears only after a full debounce from reset release.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

Decomposition:
- Shared package slot_pkg holds:
  - Channel state encoding (STABLE_LO=2'd0, PEND_HI=2'd1, STABLE_HI=2'd2, PEND_LO=2'd3), also used by the bench for state checks.
  - Default DEBOUNCE_CYCLES and SYNC_STAGES constants.
- One natural sub-module, debounce_channel: synchronizer + counter + db + rise/fall registers for a single bit. It is instantiated N_IN times via generate, plus once for START.
- The top level handles only the polarity XOR, BUSY OR-reduction, and port mapping.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
- Clean press: RAW_IN[0] 0->1 and held -> IN_LEVEL[0]=1 exactly 6 edges later; IN_RISE[0] high for that single cycle; IN_FALL=0; BUSY high during the 3 preceding cycles.
- Bounce: RAW_IN[1] toggles 1,0,1,0 each cycle, then holds 1 -> no pulses during the bounce; IN_LEVEL[1] rises 6 edges after the final 0->1; exactly one IN_RISE[1].
- Release: after a stable 1, RAW_IN[2] drops to 0 -> IN_FALL[2] single pulse at +6 edges; IN_LEVEL[2]=0.
- Start one-shot: RAW_START held high 20 cycles, then low 10, then high again -> exactly two START_PULSEs, each 1 cycle wide; START_LEVEL follows with 6-edge lag.
- Polarity and reset: ACTIVE_LOW_MASK=3'b001, RAW_IN[0]=0 at reset release -> no pulse at release; IN_RISE[0] at +6 edges. Assert RESET asynchronously mid-count on another channel -> all outputs 0 immediately; counter restarts from 0 after release.
- Simultaneity: all three RAW_IN rise on the same edge -> IN_RISE=3'b111 in one cycle.
